// File: rtl/cpu_pkg.sv
// Datapath-wide constants shared by decode, register file and writeback.
// Register 0 is the MIPS hardwired-zero register.
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// Combinational NUM_REGS:1 read mux over the flattened register array.
// Address REG_ZERO is forced to 0 regardless of what the storage holds.
module regfile_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
  input  logic [NUM_REGS*DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]          addr,
  output logic [DATA_W-1:0]          data
);

  logic [DATA_W-1:0] sel;

  always_comb begin
    sel = regs[int'(addr)*DATA_W +: DATA_W];
    data = (addr == ADDR_W'(0)) ? '0 : sel;
  end

endmodule

// File: rtl/register_file.sv
// 32x32 MIPS register file: two zero-latency read ports, one write port
// captured on the rising edge; synchronous reset wins over a same-edge write.
module register_file
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              e_write,
  output logic [DATA_W-1:0] read_d1,
  output logic [DATA_W-1:0] read_d2
);

  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic [NUM_REGS-1:0]        wr_sel;

  // r0 has no storage at all, so no write path can ever make it nonzero.
  assign regs_flat[DATA_W-1:0] = '0;
  assign wr_sel[0]             = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    logic [DATA_W-1:0] q;

    assign wr_sel[i] = e_write && (write_addr == ADDR_W'(i));

    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else if (wr_sel[i]) begin
        q <= write_data;
      end
    end

    assign regs_flat[i*DATA_W +: DATA_W] = q;
  end

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_rd1 (
    .regs(regs_flat),
    .addr(read_addr1),
    .data(read_d1)
  );

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_rd2 (
    .regs(regs_flat),
    .addr(read_addr2),
    .data(read_d2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed table, same-edge corner sequences and a randomized run against
// an array model of the architectural register state.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  read_addr1, read_addr2, write_addr;
  logic [31:0] write_data;
  logic        e_write;
  logic [31:0] read_d1, read_d2;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model [32];

  register_file dut (
    .clk       (clk),
    .rst       (rst),
    .read_addr1(read_addr1),
    .read_addr2(read_addr2),
    .write_addr(write_addr),
    .write_data(write_data),
    .e_write   (e_write),
    .read_d1   (read_d1),
    .read_d2   (read_d2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  // Drive one cycle's inputs at the falling edge, then let the rising edge act.
  task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
    @(negedge clk);
    rst = r; e_write = we; write_addr = wa; write_data = wd;
    read_addr1 = ra1; read_addr2 = ra2;
  endtask

  task automatic edge_then_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; e_write = 1'b0; write_addr = '0; write_data = '0;
    read_addr1 = '0; read_addr2 = '0;

    vecs[0] = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd0,  5'd31, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 1'b1, 5'd26, 32'hAABBCDEF, 5'd26, 5'd26, 32'hAABBCDEF, 32'hAABBCDEF};
    vecs[2] = '{1'b0, 1'b0, 5'd26, 32'h0,        5'd25, 5'd27, 32'h0,        32'h0};
    vecs[3] = '{1'b0, 1'b0, 5'd5,  32'h12345678, 5'd5,  5'd5,  32'h0,        32'h0};
    vecs[4] = '{1'b0, 1'b0, 5'd5,  32'h12345678, 5'd5,  5'd26, 32'h0,        32'hAABBCDEF};
    vecs[5] = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd26, 32'h0,        32'hAABBCDEF};
    vecs[6] = '{1'b1, 1'b1, 5'd3,  32'h1,        5'd3,  5'd26, 32'h0,        32'h0};
    vecs[7] = '{1'b0, 1'b1, 5'd3,  32'h1,        5'd3,  5'd3,  32'h1,        32'h1};

    for (int v = 0; v < 8; v++) begin
      drive(vecs[v].rst, vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra1, vecs[v].ra2);
      edge_then_settle();
      check($sformatf("vec%0d_rd1", v), read_d1, vecs[v].e1);
      check($sformatf("vec%0d_rd2", v), read_d2, vecs[v].e2);
      if (v == 0) begin
        for (int a = 0; a < 32; a++) begin
          read_addr1 = 5'(a);
          read_addr2 = 5'(31 - a);
          #1;
          check($sformatf("sweep%0d_rd1", a), read_d1, 32'h0);
          check($sformatf("sweep%0d_rd2", a), read_d2, 32'h0);
        end
      end
    end

    // Same-edge read of the register being written: old value, then new.
    drive(1'b0, 1'b1, 5'd7, 32'h11111111, 5'd7, 5'd0);
    edge_then_settle();
    drive(1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd7);
    #1;
    check("fwd_pre_edge", read_d1, 32'h11111111);
    edge_then_settle();
    check("fwd_post_edge", read_d1, 32'hDEADBEEF);
    check("fwd_post_edge_rd2", read_d2, 32'hDEADBEEF);

    // Reset mid-operation with a concurrent write, then writes resume.
    drive(1'b1, 1'b1, 5'd9, 32'h0BADF00D, 5'd9, 5'd7);
    edge_then_settle();
    check("rst_pri_r9", read_d1, 32'h0);
    check("rst_pri_r7", read_d2, 32'h0);
    drive(1'b0, 1'b1, 5'd9, 32'h0BADF00D, 5'd9, 5'd7);
    edge_then_settle();
    check("rst_resume_r9", read_d1, 32'h0BADF00D);

    // Randomized run against the model; the first cycle resets both.
    for (int c = 0; c < 400; c++) begin
      logic        r, we;
      logic [4:0]  wa, ra1, ra2;
      logic [31:0] wd;
      r   = (c == 0) || ($urandom_range(0, 24) == 0);
      we  = $urandom_range(0, 3) != 0;
      wa  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      wd  = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = 5'($urandom_range(0, 31));
      drive(r, we, wa, wd, ra1, ra2);
      #1;
      if (c > 0) begin
        check($sformatf("rnd%0d_pre_rd1", c), read_d1, model_rd(ra1));
        check($sformatf("rnd%0d_pre_rd2", c), read_d2, model_rd(ra2));
      end
      @(posedge clk);
      if (r) begin
        for (int k = 0; k < 32; k++) model[k] = 32'h0;
      end else if (we && wa != 5'd0) begin
        model[wa] = wd;
      end
      #1;
      check($sformatf("rnd%0d_post_rd1", c), read_d1, model_rd(ra1));
      check($sformatf("rnd%0d_post_rd2", c), read_d2, model_rd(ra2));
    end

    // Final full sweep of architectural state with writes disabled.
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int a = 0; a < 32; a++) begin
      read_addr1 = 5'(a);
      read_addr2 = 5'(31 - a);
      #1;
      check($sformatf("final%0d_rd1", a), read_d1, model_rd(5'(a)));
      check($sformatf("final%0d_rd2", a), read_d2, model_rd(5'(31 - a)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
